// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the core's stage-2
// memory port (priority owner) and the NIC/DMA requester. A wait counter bounds
// NIC starvation by forcing a one-cycle NIC-only slot that stalls the core.
// Read data from the 1-cycle-latency DMEM is steered back to the requester
// that issued the read.
//
// Ports:
//   clk, rst                      clock (rising edge), async active-low reset
//   core_mem_en/wr_en/addr/wdata  core stage-2 access request
//   core_rdata, core_stall        core load return, core hold request
//   nic_req/wr/addr/wdata         NIC request, held until nic_gnt
//   nic_gnt, nic_rdata, nic_rvalid NIC grant and read return
//   dmem_en/wr_en/addr/wdata      DMEM access drive (combinational pass-through)
//   dmem_rdata                    DMEM read data, one cycle after a read
module dmem_arbiter #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned MAX_WAIT   = 4,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_mem_en,
    input  logic                  core_wr_en,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic [DATA_WIDTH-1:0] core_rdata,
    output logic                  core_stall,
    input  logic                  nic_req,
    input  logic                  nic_wr,
    input  logic [ADDR_WIDTH-1:0] nic_addr,
    input  logic [DATA_WIDTH-1:0] nic_wdata,
    output logic                  nic_gnt,
    output logic [DATA_WIDTH-1:0] nic_rdata,
    output logic                  nic_rvalid,
    output logic                  dmem_en,
    output logic                  dmem_wr_en,
    output logic [ADDR_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    input  logic [DATA_WIDTH-1:0] dmem_rdata
);

    localparam logic [CNT_WIDTH-1:0] WAIT_MAX  = CNT_WIDTH'(MAX_WAIT);
    localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(MAX_WAIT - 1);
    localparam logic [1:0]           TAG_CORE  = 2'b10;
    localparam logic [1:0]           TAG_NIC   = 2'b11;

    typedef enum logic {
        S_NORMAL = 1'b0,
        S_FORCE  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]           rd_tag_q, rd_tag_d;
    logic                 own_core, own_nic, stall;
    logic                 owner_wr;

    // State, wait counter and read-return tag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_NORMAL;
            wait_cnt_q <= '0;
            rd_tag_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rd_tag_q   <= rd_tag_d;
        end
    end

    // Owner select, starvation counter and next state.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        own_core   = 1'b0;
        own_nic    = 1'b0;
        stall      = 1'b0;
        owner_wr   = 1'b0;
        rd_tag_d   = 2'b00;

        unique case (state_q)
            S_FORCE: begin
                // NIC dropped its request: the slot is not wasted, core runs.
                if (nic_req) begin
                    own_nic = 1'b1;
                    stall   = 1'b1;
                end else begin
                    own_core = core_mem_en;
                end
                state_d = S_NORMAL;
            end
            default: begin
                if (core_mem_en) begin
                    own_core = 1'b1;
                end else begin
                    own_nic = nic_req;
                end
            end
        endcase

        if ((state_q == S_FORCE) || !nic_req || own_nic) begin
            wait_cnt_d = '0;
        end else begin
            if (wait_cnt_q != WAIT_MAX) begin
                wait_cnt_d = wait_cnt_q + CNT_WIDTH'(1);
            end
            if (wait_cnt_q == WAIT_LAST) begin
                state_d = S_FORCE;
            end
        end

        owner_wr = own_nic ? nic_wr : (own_core & core_wr_en);
        if ((own_core || own_nic) && !owner_wr) begin
            rd_tag_d = {1'b1, own_nic};
        end
    end

    // DMEM drive and read steering; control outputs held low during reset.
    assign dmem_en    = rst & (own_core | own_nic);
    assign dmem_wr_en = rst & owner_wr;
    assign dmem_addr  = own_nic ? nic_addr : core_addr;
    assign dmem_wdata = own_nic ? nic_wdata : core_wdata;
    assign nic_gnt    = rst & own_nic;
    assign core_stall = rst & stall;
    assign nic_rvalid = rst & (rd_tag_q == TAG_NIC);
    assign nic_rdata  = nic_rvalid ? dmem_rdata : '0;
    assign core_rdata = (rst && (rd_tag_q == TAG_CORE)) ? dmem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1-cycle-latency DMEM.
module tb_dmem_arbiter;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 16;
    localparam logic [DW-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          core_mem_en = 1'b0, core_wr_en = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic [DW-1:0] core_rdata;
    logic          core_stall;
    logic          nic_req = 1'b0, nic_wr = 1'b0;
    logic [AW-1:0] nic_addr = '0;
    logic [DW-1:0] nic_wdata = '0;
    logic          nic_gnt, nic_rvalid;
    logic [DW-1:0] nic_rdata;
    logic          dmem_en, dmem_wr_en;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata = '0;

    logic [DW-1:0] mem [256];

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_WAIT(4), .CNT_WIDTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .core_mem_en(core_mem_en), .core_wr_en(core_wr_en),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_stall(core_stall),
        .nic_req(nic_req), .nic_wr(nic_wr), .nic_addr(nic_addr),
        .nic_wdata(nic_wdata), .nic_gnt(nic_gnt), .nic_rdata(nic_rdata),
        .nic_rvalid(nic_rvalid), .dmem_en(dmem_en), .dmem_wr_en(dmem_wr_en),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    // Single-port DMEM model: writes land at the edge, reads return next cycle.
    always @(posedge clk) begin
        if (dmem_en && dmem_wr_en) begin
            mem[dmem_addr[7:0]] <= dmem_wdata;
            dmem_rdata <= JUNK;
        end else if (dmem_en) begin
            dmem_rdata <= mem[dmem_addr[7:0]];
        end else begin
            dmem_rdata <= JUNK;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic en, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_mem_en = en; core_wr_en = wr; core_addr = a; core_wdata = d;
    endtask

    task automatic set_nic(input logic rq, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        nic_req = rq; nic_wr = wr; nic_addr = a; nic_wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h01] = 64'h11;
        mem[8'h02] = 64'h22;
        mem[8'h20] = 64'h1234;

        // Reset: outputs held low even with both requesters active.
        set_core(1'b1, 1'b1, 16'h0010, 64'hFF);
        set_nic(1'b1, 1'b0, 16'h0020, 64'h0);
        #3;
        chk("rst_dmem_en", 64'(dmem_en), 64'd0);
        chk("rst_dmem_wr_en", 64'(dmem_wr_en), 64'd0);
        chk("rst_nic_gnt", 64'(nic_gnt), 64'd0);
        chk("rst_core_stall", 64'(core_stall), 64'd0);
        chk("rst_nic_rvalid", 64'(nic_rvalid), 64'd0);
        chk("rst_core_rdata", core_rdata, 64'd0);
        set_core(1'b0, 1'b0, 16'h0, 64'h0);
        set_nic(1'b0, 1'b0, 16'h0, 64'h0);
        tick();
        tick();
        rst = 1'b1;

        // Core-only: store then load.
        set_core(1'b1, 1'b1, 16'h0010, 64'hA5);
        #2;
        chk("st_dmem_en", 64'(dmem_en), 64'd1);
        chk("st_dmem_wr_en", 64'(dmem_wr_en), 64'd1);
        chk("st_dmem_addr", 64'(dmem_addr), 64'h10);
        chk("st_dmem_wdata", dmem_wdata, 64'hA5);
        chk("st_nic_gnt", 64'(nic_gnt), 64'd0);
        tick();
        set_core(1'b1, 1'b0, 16'h0010, 64'h0);
        #2;
        chk("ld_dmem_wr_en", 64'(dmem_wr_en), 64'd0);
        chk("st_no_core_return", core_rdata, 64'd0);
        chk("st_no_nic_return", 64'(nic_rvalid), 64'd0);
        tick();
        set_core(1'b0, 1'b0, 16'h0, 64'h0);
        #2;
        chk("ld_core_rdata", core_rdata, 64'hA5);
        chk("ld_nic_rvalid", 64'(nic_rvalid), 64'd0);
        chk("idle_dmem_en", 64'(dmem_en), 64'd0);

        // NIC on idle bus.
        tick();
        set_nic(1'b1, 1'b0, 16'h0020, 64'h0);
        #2;
        chk("nic_idle_gnt", 64'(nic_gnt), 64'd1);
        chk("nic_idle_stall", 64'(core_stall), 64'd0);
        chk("nic_idle_addr", 64'(dmem_addr), 64'h20);
        tick();
        set_nic(1'b0, 1'b0, 16'h0, 64'h0);
        #2;
        chk("nic_idle_rvalid", 64'(nic_rvalid), 64'd1);
        chk("nic_idle_rdata", nic_rdata, 64'h1234);
        chk("nic_idle_core_rdata", core_rdata, 64'd0);

        // Starvation bound: 4 denials, then forced NIC write.
        tick();
        set_core(1'b1, 1'b0, 16'h0001, 64'h0);
        set_nic(1'b1, 1'b1, 16'h0030, 64'hBEEF);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("starve_deny%0d_gnt", i), 64'(nic_gnt), 64'd0);
            chk($sformatf("starve_deny%0d_stall", i), 64'(core_stall), 64'd0);
            tick();
        end
        #2;
        chk("force_gnt", 64'(nic_gnt), 64'd1);
        chk("force_stall", 64'(core_stall), 64'd1);
        chk("force_addr", 64'(dmem_addr), 64'h30);
        chk("force_wr_en", 64'(dmem_wr_en), 64'd1);
        tick();
        set_nic(1'b0, 1'b0, 16'h0, 64'h0);
        #2;
        chk("after_force_core_served", 64'(dmem_addr), 64'h01);
        chk("after_force_stall", 64'(core_stall), 64'd0);
        chk("after_force_no_return", core_rdata, 64'd0);
        chk("force_write_landed", mem[8'h30], 64'hBEEF);

        // NIC drops during the forced slot: core runs, no stall.
        tick();
        set_nic(1'b1, 1'b0, 16'h0020, 64'h0);
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("drop_deny%0d_gnt", i), 64'(nic_gnt), 64'd0);
            tick();
        end
        set_nic(1'b0, 1'b0, 16'h0, 64'h0);
        #2;
        chk("drop_stall", 64'(core_stall), 64'd0);
        chk("drop_gnt", 64'(nic_gnt), 64'd0);
        chk("drop_core_en", 64'(dmem_en), 64'd1);
        chk("drop_core_addr", 64'(dmem_addr), 64'h01);
        tick();
        set_nic(1'b1, 1'b0, 16'h0020, 64'h0);
        #2;
        chk("drop_core_rdata", core_rdata, 64'h11);
        // Back in S_NORMAL with a fresh count: 4 denials (this cycle + 3).
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("renorm_deny%0d_gnt", i), 64'(nic_gnt), 64'd0);
            tick();
            #1;
        end
        #1;
        chk("pre_reset_force_stall", 64'(core_stall), 64'd1);

        // Async reset in the forced slot.
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_gnt", 64'(nic_gnt), 64'd0);
        chk("mid_rst_stall", 64'(core_stall), 64'd0);
        chk("mid_rst_dmem_en", 64'(dmem_en), 64'd0);
        chk("mid_rst_core_rdata", core_rdata, 64'd0);
        chk("mid_rst_nic_rvalid", 64'(nic_rvalid), 64'd0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk($sformatf("post_rst_deny%0d_gnt", i), 64'(nic_gnt), 64'd0);
            tick();
        end
        #2;
        chk("post_rst_force_gnt", 64'(nic_gnt), 64'd1);
        chk("post_rst_force_stall", 64'(core_stall), 64'd1);
        tick();
        set_nic(1'b0, 1'b0, 16'h0, 64'h0);
        set_core(1'b0, 1'b0, 16'h0, 64'h0);
        #2;
        chk("post_rst_nic_rdata", nic_rdata, 64'h1234);

        // Back-to-back owner switch: core read then NIC read.
        tick();
        set_core(1'b1, 1'b0, 16'h0001, 64'h0);
        tick();
        set_core(1'b0, 1'b0, 16'h0, 64'h0);
        set_nic(1'b1, 1'b0, 16'h0002, 64'h0);
        #2;
        chk("b2b_nic_gnt", 64'(nic_gnt), 64'd1);
        chk("b2b_core_rdata", core_rdata, 64'h11);
        chk("b2b_nic_rvalid0", 64'(nic_rvalid), 64'd0);
        tick();
        set_nic(1'b0, 1'b0, 16'h0, 64'h0);
        #2;
        chk("b2b_core_rdata_clr", core_rdata, 64'd0);
        chk("b2b_nic_rvalid", 64'(nic_rvalid), 64'd1);
        chk("b2b_nic_rdata", nic_rdata, 64'h22);
        tick();
        #2;
        chk("b2b_nic_rvalid_clr", 64'(nic_rvalid), 64'd0);
        chk("b2b_nic_rdata_clr", nic_rdata, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
